instruction_dispatcher: RTL and testbench
=========================================

Name: instruction_dispatcher

Overview:
- Sequences the opcode and start pulse issued by the CPU register interface: decodes the opcode group, checks it against the current video mode, and starts the text engine, the graphics engine or the palette unit.
- Watches the selected unit's handshake and guards it with a watchdog.
- Drives the aggregated busy/finished/error status and the two result bytes back to the CPU interface.
- Sits in the phi2 domain between the CPU register interface and the execution engines.

Parameters:
- TIMEOUT_CYCLES, 4096: WAIT cycles allowed before the watchdog aborts an instruction; legal range 2..65535.
- PALETTE_CYCLES, 2: fixed completion latency of palette operations, counted in WAIT; legal range 1..15.

Ports:
- phi2 input 1: system clock; all logic on rising edge.
- reset input 1: asynchronous, active-high reset.
- instruction input 8: opcode, valid while instruction_start=1.
- instruction_start input 1: one-cycle start request.
- mode_control input 8: bit0 0=text mode, 1=graphics mode; other bits ignored.
- instruction_busy output 1: high while an instruction is in progress.
- instruction_finished output 1: one-cycle completion pulse.
- instruction_error output 1: error status of the last instruction.
- result_0 output 8: result byte 0 ($000D).
- result_1 output 8: result byte 1 ($000E).
- text_start output 1: one-cycle start to the text engine.
- text_done input 1: text engine completion pulse.
- text_error input 1: text engine error, sampled with text_done.
- text_result_0 input 8: text engine result byte 0.
- text_result_1 input 8: text engine result byte 1.
- gfx_start output 1: one-cycle start to the graphics engine.
- gfx_done input 1: graphics engine completion pulse.
- gfx_error input 1: graphics engine error, sampled with gfx_done.
- gfx_result_0 input 8: graphics engine result byte 0.
- gfx_result_1 input 8: graphics engine result byte 1.
- palette_result_low input 8: palette read result, low byte.
- palette_result_high input 8: palette read result, high byte.
- engine_abort output 1: one-cycle abort pulse to the active engine on timeout.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; result_0=result_1=8'h00; counters 0. engine_abort is not pulsed on reset.
- Opcode groups:
  - TEXT: 00..04.
  - GFX: 10..14.
  - PAL: 20, 21.
  - Any other opcode is INVALID.
- States:
  - IDLE: on instruction_start=1, latch opcode and group, clear instruction_error, go to ISSUE. Otherwise hold.
  - ISSUE (1 cycle): busy=1.
    - TEXT with mode bit0=0: text_start=1, go to WAIT.
    - GFX with mode bit0=1: gfx_start=1, go to WAIT.
    - PAL in either mode: no start, go to WAIT.
    - INVALID, or mode mismatch: set error flag, go to COMPLETE without starting any engine.
  - WAIT: busy=1; wait counter increments every cycle starting at 0.
    - TEXT/GFX: the selected unit's done=1 → capture that unit's error into the error flag and its result_0/1 into the result registers, go to COMPLETE.
    - PAL: when the counter reaches PALETTE_CYCLES-1, go to COMPLETE. Opcode 21 captures palette_result_low→result_0 and palette_result_high→result_1; opcode 20 leaves the results unchanged.
    - Counter reaches TIMEOUT_CYCLES-1 without done: engine_abort=1 for one cycle, set error flag, go to COMPLETE.
  - COMPLETE (1 cycle): busy=0, instruction_finished=1, instruction_error=error flag; then IDLE.
- Results:
  - Text/graphics results are captured only for opcodes 03 and 14; all other opcodes leave result_0/1 unchanged.
  - Result registers persist until the next capture.
- instruction_error is a level: it holds from COMPLETE until the next accepted instruction_start.
- Latency: start sampled at cycle N → ISSUE at N+1 (busy high, engine start high) → WAIT from N+2. Done sampled at cycle M → finished at M+1. Palette: finished at N+2+PALETTE_CYCLES.
- Boundary conditions:
  - done ignored outside WAIT.
  - done of the non-selected engine ignored.
  - done and timeout in the same cycle: done wins, no abort.
  - instruction_start outside IDLE: ignored, no state change.
  - instruction_start in the COMPLETE cycle: ignored.
  - mode_control is sampled in the ISSUE cycle only; mode changes during WAIT do not affect the running instruction.

Test Plan:
1. mode=00, start op 00 → text_start high at N+1; text_done at N+5 with text_error=0 → finished at N+6, busy low at N+6, error=0, results unchanged.
2. mode=00, op 03, text_done with text_result_0=41, text_result_1=07 → result_0=41, result_1=07 in the COMPLETE cycle. Then op 00 → results still 41/07.
3. mode=00, op 10 (mode mismatch) → no gfx_start; finished at N+2, error=1. Next start op 00 with clean completion → error clears at accept, stays 0.
4. mode=01, op 21, palette_result_low=5A, palette_result_high=F0, PALETTE_CYCLES=2 → finished at N+4, result_0=5A, result_1=F0. Op 77 → error=1, finished at N+2.
5. TIMEOUT_CYCLES=8, op 13 in mode=01, gfx_done never asserted → engine_abort pulse in the 8th WAIT cycle, finished next cycle, error=1. Repeat with gfx_done in that same cycle → no abort, error=gfx_error.
6. Assert reset during WAIT → all outputs 0 immediately, results 00. Start pulse during busy → ignored: no second engine start, a single finished pulse.

Source files
------------

// File: rtl/instruction_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_dispatcher_if
// Brief    : CPU-side and engine-side handshake/bus bundle of the
//            instruction dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_dispatcher_if;
    // CPU register interface
    logic [7:0] instruction;
    logic       instruction_start;
    logic [7:0] mode_control;
    logic       instruction_busy;
    logic       instruction_finished;
    logic       instruction_error;
    logic [7:0] result_0;
    logic [7:0] result_1;
    // Text engine
    logic       text_start;
    logic       text_done;
    logic       text_error;
    logic [7:0] text_result_0;
    logic [7:0] text_result_1;
    // Graphics engine
    logic       gfx_start;
    logic       gfx_done;
    logic       gfx_error;
    logic [7:0] gfx_result_0;
    logic [7:0] gfx_result_1;
    // Palette unit
    logic [7:0] palette_result_low;
    logic [7:0] palette_result_high;
    // Shared engine abort
    logic       engine_abort;

    // Dispatcher side
    modport master (
        input  instruction, instruction_start, mode_control,
        output instruction_busy, instruction_finished, instruction_error,
        output result_0, result_1,
        output text_start,
        input  text_done, text_error, text_result_0, text_result_1,
        output gfx_start,
        input  gfx_done, gfx_error, gfx_result_0, gfx_result_1,
        input  palette_result_low, palette_result_high,
        output engine_abort
    );

    // CPU interface / engines side
    modport slave (
        output instruction, instruction_start, mode_control,
        input  instruction_busy, instruction_finished, instruction_error,
        input  result_0, result_1,
        input  text_start,
        output text_done, text_error, text_result_0, text_result_1,
        input  gfx_start,
        output gfx_done, gfx_error, gfx_result_0, gfx_result_1,
        output palette_result_low, palette_result_high,
        input  engine_abort
    );
endinterface
`default_nettype wire

// File: rtl/instruction_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : instruction_dispatcher
// Brief    : Decodes CPU opcodes, checks them against the video mode,
//            launches the text/graphics engine or palette unit, watches the
//            handshake under a watchdog and reports status/results.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_dispatcher #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int PALETTE_CYCLES = 2
) (
    input  wire logic                  phi2,
    input  wire logic                  reset,
    instruction_dispatcher_if.master   bus
);

    typedef enum logic [1:0] {
        c_IDLE     = 2'd0,
        c_ISSUE    = 2'd1,
        c_WAIT     = 2'd2,
        c_COMPLETE = 2'd3
    } state_t;

    localparam logic [1:0]  c_GRP_TEXT = 2'd0;
    localparam logic [1:0]  c_GRP_GFX  = 2'd1;
    localparam logic [1:0]  c_GRP_PAL  = 2'd2;
    localparam logic [1:0]  c_GRP_INV  = 2'd3;
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] c_PAL_LAST = 16'(PALETTE_CYCLES - 1);

    function automatic logic [1:0] f_group(input logic [7:0] op);
        if (op <= 8'h04)                      return c_GRP_TEXT;
        else if (op >= 8'h10 && op <= 8'h14)  return c_GRP_GFX;
        else if (op == 8'h20 || op == 8'h21)  return c_GRP_PAL;
        else                                  return c_GRP_INV;
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_opcode;
    logic [1:0]  r_group;
    logic [15:0] r_count;
    logic        r_err;
    logic [7:0]  r_res0;
    logic [7:0]  r_res1;

    logic        w_accept;
    logic        w_load_err;
    logic        w_err_val;
    logic        w_cap_res;
    logic [7:0]  w_cap_r0;
    logic [7:0]  w_cap_r1;
    logic        w_text_start;
    logic        w_gfx_start;
    logic        w_abort;

    // Next-state decode plus engine strobes and capture controls
    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_load_err   = 1'b0;
        w_err_val    = 1'b0;
        w_cap_res    = 1'b0;
        w_cap_r0     = 8'h00;
        w_cap_r1     = 8'h00;
        w_text_start = 1'b0;
        w_gfx_start  = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (bus.instruction_start) begin
                    w_accept = 1'b1;
                    w_next   = c_ISSUE;
                end
            end
            c_ISSUE: begin
                // Mode is only looked at here; later mode changes are harmless
                if (r_group == c_GRP_TEXT && !bus.mode_control[0]) begin
                    w_text_start = 1'b1;
                    w_next       = c_WAIT;
                end else if (r_group == c_GRP_GFX && bus.mode_control[0]) begin
                    w_gfx_start = 1'b1;
                    w_next      = c_WAIT;
                end else if (r_group == c_GRP_PAL) begin
                    w_next = c_WAIT;
                end else begin
                    w_load_err = 1'b1;
                    w_err_val  = 1'b1;
                    w_next     = c_COMPLETE;
                end
            end
            c_WAIT: begin
                // Completion is tested before the watchdog so done wins a tie
                if (r_group == c_GRP_TEXT && bus.text_done) begin
                    w_load_err = 1'b1;
                    w_err_val  = bus.text_error;
                    w_cap_res  = (r_opcode == 8'h03);
                    w_cap_r0   = bus.text_result_0;
                    w_cap_r1   = bus.text_result_1;
                    w_next     = c_COMPLETE;
                end else if (r_group == c_GRP_GFX && bus.gfx_done) begin
                    w_load_err = 1'b1;
                    w_err_val  = bus.gfx_error;
                    w_cap_res  = (r_opcode == 8'h14);
                    w_cap_r0   = bus.gfx_result_0;
                    w_cap_r1   = bus.gfx_result_1;
                    w_next     = c_COMPLETE;
                end else if (r_group == c_GRP_PAL && r_count == c_PAL_LAST) begin
                    w_cap_res  = (r_opcode == 8'h21);
                    w_cap_r0   = bus.palette_result_low;
                    w_cap_r1   = bus.palette_result_high;
                    w_next     = c_COMPLETE;
                end else if (r_count == c_TMO_LAST) begin
                    w_abort    = 1'b1;
                    w_load_err = 1'b1;
                    w_err_val  = 1'b1;
                    w_next     = c_COMPLETE;
                end
            end
            c_COMPLETE: begin
                w_next = c_IDLE;
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    // State, latched instruction, watchdog counter, error flag and results
    always_ff @(posedge phi2 or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_opcode <= 8'h00;
            r_group  <= c_GRP_TEXT;
            r_count  <= 16'h0000;
            r_err    <= 1'b0;
            r_res0   <= 8'h00;
            r_res1   <= 8'h00;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_opcode <= bus.instruction;
                r_group  <= f_group(bus.instruction);
            end
            if (r_state == c_ISSUE) begin
                r_count <= 16'h0000;
            end else if (r_state == c_WAIT) begin
                r_count <= r_count + 16'h0001;
            end
            // Error is a level: cleared on accept, held after completion
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_load_err) begin
                r_err <= w_err_val;
            end
            if (w_cap_res) begin
                r_res0 <= w_cap_r0;
                r_res1 <= w_cap_r1;
            end
        end
    end

    assign bus.instruction_busy     = (r_state == c_ISSUE) || (r_state == c_WAIT);
    assign bus.instruction_finished = (r_state == c_COMPLETE);
    assign bus.instruction_error    = r_err;
    assign bus.result_0             = r_res0;
    assign bus.result_1             = r_res1;
    assign bus.text_start           = w_text_start;
    assign bus.gfx_start            = w_gfx_start;
    assign bus.engine_abort         = w_abort;

endmodule
`default_nettype wire

// File: tb/tb_instruction_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_dispatcher
// Brief    : Self-checking bench for instruction_dispatcher: directed
//            scenarios followed by randomized instructions, checked each cycle
//            against an instruction-level timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_dispatcher;

    localparam int c_T = 8;
    localparam int c_P = 2;

    logic phi2;
    logic reset;
    int   total;
    int   bad;

    // Model state carried between instructions
    logic [7:0] m_r0;
    logic [7:0] m_r1;
    logic       m_err;

    instruction_dispatcher_if bus ();

    instruction_dispatcher #(
        .TIMEOUT_CYCLES (c_T),
        .PALETTE_CYCLES (c_P)
    ) dut (
        .phi2  (phi2),
        .reset (reset),
        .bus   (bus)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic quiet_inputs();
        bus.instruction         = 8'h00;
        bus.instruction_start   = 1'b0;
        bus.mode_control        = 8'h00;
        bus.text_done           = 1'b0;
        bus.text_error          = 1'b0;
        bus.text_result_0       = 8'h00;
        bus.text_result_1       = 8'h00;
        bus.gfx_done            = 1'b0;
        bus.gfx_error           = 1'b0;
        bus.gfx_result_0        = 8'h00;
        bus.gfx_result_1        = 8'h00;
        bus.palette_result_low  = 8'h00;
        bus.palette_result_high = 8'h00;
    endtask

    // 0 = text, 1 = graphics, 2 = palette, 3 = invalid
    function automatic int grp_of(input logic [7:0] op);
        if (op inside {[8'h00:8'h04]}) return 0;
        if (op inside {[8'h10:8'h14]}) return 1;
        if (op inside {8'h20, 8'h21})  return 2;
        return 3;
    endfunction

    // One instruction: start at step 0, done of the selected engine at step d
    // (negative = never). With noise, unrelated inputs toggle randomly and
    // spurious starts are issued while the instruction is in flight.
    task automatic run(input logic [7:0] op, input logic [7:0] mode, input int d,
                       input logic derr, input logic [7:0] dr0, input logic [7:0] dr1,
                       input logic [7:0] plo, input logic [7:0] phi, input bit noise);
        int         g;
        bit         legal;
        int         sel;
        int         fin;
        int         abrt;
        logic       eerr;
        bit         cap;
        logic [7:0] n0;
        logic [7:0] n1;
        g     = grp_of(op);
        legal = (g == 2) || (g == 0 && !mode[0]) || (g == 1 && mode[0]);
        sel   = !legal ? 2 : (g == 0 ? 0 : (g == 1 ? 1 : 2));
        abrt  = -1;
        cap   = 1'b0;
        n0    = m_r0;
        n1    = m_r1;
        if (!legal) begin
            fin  = 2;
            eerr = 1'b1;
        end else if (g == 2) begin
            fin  = 2 + c_P;
            eerr = 1'b0;
            cap  = (op == 8'h21);
            n0   = plo;
            n1   = phi;
        end else if (d >= 2 && d <= c_T + 1) begin
            fin  = d + 1;
            eerr = derr;
            cap  = (g == 0 && op == 8'h03) || (g == 1 && op == 8'h14);
            n0   = dr0;
            n1   = dr1;
        end else begin
            abrt = c_T + 1;
            fin  = c_T + 2;
            eerr = 1'b1;
        end
        if (!cap) begin
            n0 = m_r0;
            n1 = m_r1;
        end
        for (int s = 0; s <= fin + 1; s++) begin
            bit         in_wait;
            logic [7:0] xr0;
            logic [7:0] xr1;
            in_wait = (s >= 2) && (s < fin);
            bus.instruction_start = (s == 0) ||
                                    (noise && s >= 1 && s <= fin && ($urandom_range(0, 2) == 0));
            bus.instruction  = (s == 0) ? op : 8'($urandom);
            bus.mode_control = (s == 1) ? mode : (noise ? 8'($urandom) : mode);
            bus.text_done = (sel == 0 && s == d) ||
                            (noise && !(sel == 0 && in_wait) && ($urandom_range(0, 3) == 0));
            bus.gfx_done  = (sel == 1 && s == d) ||
                            (noise && !(sel == 1 && in_wait) && ($urandom_range(0, 3) == 0));
            bus.text_error    = (sel == 0 && s == d) ? derr : (noise ? 1'($urandom) : 1'b0);
            bus.gfx_error     = (sel == 1 && s == d) ? derr : (noise ? 1'($urandom) : 1'b0);
            bus.text_result_0 = (sel == 0 && s == d) ? dr0 : (noise ? 8'($urandom) : 8'h00);
            bus.text_result_1 = (sel == 0 && s == d) ? dr1 : (noise ? 8'($urandom) : 8'h00);
            bus.gfx_result_0  = (sel == 1 && s == d) ? dr0 : (noise ? 8'($urandom) : 8'h00);
            bus.gfx_result_1  = (sel == 1 && s == d) ? dr1 : (noise ? 8'($urandom) : 8'h00);
            bus.palette_result_low  = (g == 2 && s == fin - 1) ? plo : (noise ? 8'($urandom) : 8'h00);
            bus.palette_result_high = (g == 2 && s == fin - 1) ? phi : (noise ? 8'($urandom) : 8'h00);
            @(negedge phi2);
            xr0 = (s >= fin) ? n0 : m_r0;
            xr1 = (s >= fin) ? n1 : m_r1;
            chk($sformatf("busy op=%h s=%0d", op, s), 8'(bus.instruction_busy), 8'(s >= 1 && s < fin));
            chk($sformatf("finished op=%h s=%0d", op, s), 8'(bus.instruction_finished), 8'(s == fin));
            chk($sformatf("error op=%h s=%0d", op, s), 8'(bus.instruction_error),
                8'((s == 0) ? m_err : ((s >= fin) ? eerr : 1'b0)));
            chk($sformatf("text_start op=%h s=%0d", op, s), 8'(bus.text_start), 8'(s == 1 && sel == 0));
            chk($sformatf("gfx_start op=%h s=%0d", op, s), 8'(bus.gfx_start), 8'(s == 1 && sel == 1));
            chk($sformatf("abort op=%h s=%0d", op, s), 8'(bus.engine_abort), 8'(s == abrt));
            chk($sformatf("result_0 op=%h s=%0d", op, s), bus.result_0, xr0);
            chk($sformatf("result_1 op=%h s=%0d", op, s), bus.result_1, xr1);
            @(posedge phi2);
            #1;
        end
        quiet_inputs();
        m_err = eerr;
        m_r0  = n0;
        m_r1  = n1;
    endtask

    initial begin
        logic [7:0] ops [0:15];
        total = 0;
        bad   = 0;
        m_r0  = 8'h00;
        m_r1  = 8'h00;
        m_err = 1'b0;
        quiet_inputs();

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge phi2);
        #1;
        chk("reset busy", 8'(bus.instruction_busy), 8'h00);
        chk("reset finished", 8'(bus.instruction_finished), 8'h00);
        chk("reset error", 8'(bus.instruction_error), 8'h00);
        chk("reset result_0", bus.result_0, 8'h00);
        chk("reset result_1", bus.result_1, 8'h00);
        chk("reset abort", 8'(bus.engine_abort), 8'h00);
        reset = 1'b0;
        @(posedge phi2);
        #1;

        // Plain text op, done at step 5, results untouched
        run(8'h00, 8'h00, 5, 1'b0, 8'h11, 8'h22, 8'h00, 8'h00, 1'b0);
        // Text op 03 captures results; a following op 00 leaves them
        run(8'h03, 8'h00, 4, 1'b0, 8'h41, 8'h07, 8'h00, 8'h00, 1'b0);
        run(8'h00, 8'h00, 3, 1'b0, 8'h99, 8'h88, 8'h00, 8'h00, 1'b0);
        // Mode mismatch, then a clean op clears the error
        run(8'h10, 8'h00, -1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        run(8'h00, 8'h00, 2, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        // Palette read, then an invalid opcode
        run(8'h21, 8'h01, -1, 1'b0, 8'h00, 8'h00, 8'h5A, 8'hF0, 1'b0);
        run(8'h77, 8'h01, -1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        // Palette write keeps results
        run(8'h20, 8'h00, -1, 1'b0, 8'h00, 8'h00, 8'h12, 8'h34, 1'b0);
        // Watchdog timeout, then done in the timeout cycle
        run(8'h13, 8'h01, -1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        run(8'h13, 8'h01, c_T + 1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        run(8'h14, 8'h01, c_T + 1, 1'b1, 8'hC3, 8'h3C, 8'h00, 8'h00, 1'b0);
        // Spurious starts and foreign dones while busy
        run(8'h03, 8'h00, 6, 1'b1, 8'hAB, 8'hCD, 8'h00, 8'h00, 1'b1);

        // Randomized instructions
        ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h12,
                8'h13, 8'h14, 8'h20, 8'h21, 8'h05, 8'h0F, 8'h22, 8'hFF};
        for (int i = 0; i < 200; i++) begin
            logic [7:0] op;
            op = ($urandom_range(0, 7) == 0) ? 8'($urandom) : ops[$urandom_range(0, 15)];
            run(op, 8'($urandom), int'($urandom_range(1, c_T + 3)), 1'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        end

        // Asynchronous reset in the middle of WAIT
        bus.instruction       = 8'h03;
        bus.instruction_start = 1'b1;
        bus.mode_control      = 8'h00;
        @(posedge phi2);
        #1;
        bus.instruction_start = 1'b0;
        repeat (2) @(posedge phi2);
        #3;
        chk("pre-reset busy", 8'(bus.instruction_busy), 8'h01);
        reset = 1'b1;
        #1;
        chk("async reset busy", 8'(bus.instruction_busy), 8'h00);
        chk("async reset finished", 8'(bus.instruction_finished), 8'h00);
        chk("async reset error", 8'(bus.instruction_error), 8'h00);
        chk("async reset text_start", 8'(bus.text_start), 8'h00);
        chk("async reset abort", 8'(bus.engine_abort), 8'h00);
        chk("async reset result_0", bus.result_0, 8'h00);
        chk("async reset result_1", bus.result_1, 8'h00);
        @(posedge phi2);
        #1;
        reset = 1'b0;
        m_r0  = 8'h00;
        m_r1  = 8'h00;
        m_err = 1'b0;
        @(posedge phi2);
        #1;
        run(8'h12, 8'h01, 3, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
